// File: rtl/spi_master_pkg.sv
// -----------------------------------------------------------------------------
// spi_master_pkg
// Shared definitions for the SPI initiator and the slave-side decode:
//   - spi_state_e   : FSM state encoding (3 bits)
//   - SPI_FRAME_BITS: bits per transaction frame (command byte + data byte)
//   - SPI_CMD_BITS  : bits in the command byte {addr[6:0], rw}
//   - SPI_RW_READ   : value of the rw bit that selects a read
//   - is_data_bit() : true when a frame bit index falls in the data byte
// No ports; imported with `import spi_master_pkg::*;`.
// -----------------------------------------------------------------------------
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4
  } spi_state_e;

  localparam int         SPI_FRAME_BITS = 16;
  localparam int         SPI_CMD_BITS   = 8;
  localparam logic       SPI_RW_READ    = 1'b1;
  localparam logic [3:0] SPI_LAST_BIT   = 4'(SPI_FRAME_BITS - 1);

  // Bits 0..7 of a frame carry the command, 8..15 carry the data byte.
  function automatic logic is_data_bit(input logic [3:0] bit_idx);
    return (bit_idx >= 4'(SPI_CMD_BITS));
  endfunction

endpackage : spi_master_pkg

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen
// Divider that paces the SPI master. Counts 0..DIVIDER-1 while enabled and
// flags the last clk of every SCLK half-period.
// Parameters:
//   DIVIDER   clk cycles per SCLK half-period (>= 4)
// Ports:
//   clk        in  1  system clock
//   reset_n    in  1  synchronous active-low reset
//   enable     in  1  count while high; counter held at 0 while low
//   half_tick  out 1  high on the last clk of each half-period
// -----------------------------------------------------------------------------
module spi_sclk_gen #(
  parameter int DIVIDER = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic half_tick
);

  localparam int            CW       = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIVIDER - 1);

  logic [CW-1:0] div_q;
  logic [CW-1:0] div_d;

  // While disabled the counter sits at zero, so every frame starts with a
  // full-length first half-period regardless of what happened before.
  always_comb begin
    div_d = '0;
    if (enable) begin
      div_d = (div_q == DIV_LAST) ? '0 : div_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign half_tick = enable && (div_q == DIV_LAST);

endmodule : spi_sclk_gen

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// SPI initiator, mode 0, MSB first. Each transaction is a 16-bit frame: the
// command byte {addr[6:0], rw} followed by one data byte. Writes shift wdata
// out on MOSI; reads hold MOSI low for the data byte and capture MISO.
// Parameters:
//   DIVIDER   clk cycles per SCLK half-period (>= 4)
// Ports:
//   clk      in  1  system clock
//   reset_n  in  1  synchronous active-low reset
//   start    in  1  request a transaction (sampled only while busy=0)
//   addr     in  7  target address, latched on accept
//   rw       in  1  1=read, 0=write, latched on accept
//   wdata    in  8  write data, latched on accept
//   busy     out 1  high from the cycle after accept until done
//   done     out 1  one-cycle pulse at the end of a transaction
//   rdata    out 8  last read result, updated in the done cycle of a read
//   sclk     out 1  SPI clock, idles low
//   cs       out 1  chip select, active low, idles high
//   mosi     out 1  serial data to slave, idles low
//   miso     in  1  serial data from slave
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module spi_master
  import spi_master_pkg::*;
#(
  parameter int DIVIDER = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs,
  output logic       mosi,
  input  logic       miso
);

  spi_state_e  state_q, state_d;
  logic [15:0] shreg_q, shreg_d;
  logic        rw_q, rw_d;
  logic [3:0]  bit_q, bit_d;
  logic        phase_q, phase_d;
  logic [7:0]  rx_q, rx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        sclk_q, sclk_d;
  logic        cs_q, cs_d;
  logic        mosi_q, mosi_d;

  logic        half_tick;
  logic [3:0]  bit_next;

  spi_sclk_gen #(
    .DIVIDER (DIVIDER)
  ) u_sclk_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (state_q != ST_IDLE),
    .half_tick (half_tick)
  );

  assign bit_next = bit_q + 4'd1;

  // Next-state and output logic. The frame walks SETUP -> SHIFT -> HOLD ->
  // GAP, each step paced by half_tick. After GAP the FSM is back in IDLE but
  // busy is still high for one cycle; that cycle retires the frame (raises
  // done, publishes read data) and keeps a start held high from being taken
  // until the done cycle itself. The shift register rotates rather than
  // shifts, and MOSI is loaded one bit ahead from shreg_q[14]. Read frames
  // force MOSI low through the data byte.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    rw_d    = rw_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    rx_d    = rx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    cs_d    = cs_q;
    mosi_d  = mosi_q;

    unique case (state_q)
      ST_IDLE: begin
        sclk_d = 1'b0;
        cs_d   = 1'b1;
        mosi_d = 1'b0;
        if (busy_q) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          if (rw_q == SPI_RW_READ) begin
            rdata_d = rx_q;
          end
        end else if (start) begin
          state_d = ST_SETUP;
          shreg_d = {addr, rw, wdata};
          rw_d    = rw;
          bit_d   = 4'd0;
          phase_d = 1'b0;
          busy_d  = 1'b1;
          cs_d    = 1'b0;
          mosi_d  = addr[6];
        end
      end

      ST_SETUP: begin
        if (half_tick) begin
          state_d = ST_SHIFT;
          phase_d = 1'b0;
        end
      end

      ST_SHIFT: begin
        if (half_tick) begin
          if (!phase_q) begin
            phase_d = 1'b1;
            sclk_d  = 1'b1;
          end else begin
            phase_d = 1'b0;
            sclk_d  = 1'b0;
            if (is_data_bit(bit_q)) begin
              rx_d = {rx_q[6:0], miso};
            end
            if (bit_q == SPI_LAST_BIT) begin
              state_d = ST_HOLD;
              mosi_d  = 1'b0;
            end else begin
              bit_d   = bit_next;
              shreg_d = {shreg_q[14:0], shreg_q[15]};
              if ((rw_q == SPI_RW_READ) && is_data_bit(bit_next)) begin
                mosi_d = 1'b0;
              end else begin
                mosi_d = shreg_q[14];
              end
            end
          end
        end
      end

      ST_HOLD: begin
        if (half_tick) begin
          state_d = ST_GAP;
          cs_d    = 1'b1;
        end
      end

      ST_GAP: begin
        if (half_tick) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight without
  // a done pulse.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      rw_q    <= 1'b0;
      bit_q   <= '0;
      phase_q <= 1'b0;
      rx_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      rw_q    <= rw_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
      sclk_q  <= sclk_d;
      cs_q    <= cs_d;
      mosi_q  <= mosi_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign sclk  = sclk_q;
  assign cs    = cs_q;
  assign mosi  = mosi_q;

endmodule : spi_master

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Two masters (DIVIDER=4 and DIVIDER=16), each wired to a behavioural mode-0
// slave with its own memory. Stimulus pushes transaction records into a
// scoreboard queue; the monitor pops one per done pulse and predicts rdata
// from a reference memory, plus frame contents, SCLK count and latency.
// -----------------------------------------------------------------------------
module tb_spi_master;

  localparam int HALF0 = 4;
  localparam int HALF1 = 16;

  typedef struct {
    int         inst;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    int         accept;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_r [2];
  logic [6:0] addr_r  [2];
  logic       rw_r    [2];
  logic [7:0] wdata_r [2];
  logic       miso_r  [2];
  logic       busy_w  [2];
  logic       done_w  [2];
  logic [7:0] rdata_w [2];
  logic       sclk_w  [2];
  logic       cs_w    [2];
  logic       mosi_w  [2];

  exp_t       sb [$];
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         done_cnt [2];
  logic [7:0] ref_mem [2][128];
  logic [7:0] slv_mem [2][128];
  logic [7:0] last_rdata [2];

  // Slave model state
  logic       s_prev_sclk [2];
  logic       s_prev_cs   [2];
  int         s_rises     [2];
  logic [7:0] s_cmd       [2];
  logic [7:0] s_dat       [2];
  logic [7:0] last_cmd    [2];
  logic [7:0] last_dat    [2];
  int         last_rises  [2];

  // Monitor state
  int         cs_run  [2];
  logic       cs_seen [2];
  logic       m_prev_cs [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  spi_master #(.DIVIDER(HALF0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_r[0]), .addr(addr_r[0]),
    .rw(rw_r[0]), .wdata(wdata_r[0]), .busy(busy_w[0]), .done(done_w[0]),
    .rdata(rdata_w[0]), .sclk(sclk_w[0]), .cs(cs_w[0]), .mosi(mosi_w[0]),
    .miso(miso_r[0])
  );

  spi_master #(.DIVIDER(HALF1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_r[1]), .addr(addr_r[1]),
    .rw(rw_r[1]), .wdata(wdata_r[1]), .busy(busy_w[1]), .done(done_w[1]),
    .rdata(rdata_w[1]), .sclk(sclk_w[1]), .cs(cs_w[1]), .mosi(mosi_w[1]),
    .miso(miso_r[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, actual, expected, cyc);
    end
  endtask

  // Wait for the master to be free, present one request and log it. With
  // hold=1 start stays high afterwards.
  task automatic applyStimulus(input int inst, input logic [6:0] a,
                               input logic r, input logic [7:0] w,
                               input bit hold);
    int n = 0;
    while (busy_w[inst] !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_wait", {31'd0, busy_w[inst]}, 32'd0);
    addr_r[inst]  = a;
    rw_r[inst]    = r;
    wdata_r[inst] = w;
    start_r[inst] = 1'b1;
    sb.push_back('{inst, a, r, w, cyc + 1});
    @(negedge clk);
    if (!hold) start_r[inst] = 1'b0;
  endtask

  task automatic waitIdle(input int inst);
    int n = 0;
    while ((sb.size() != 0 || busy_w[inst] !== 1'b0) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_wait", sb.size(), 32'd0);
  endtask

  // Behavioural mode-0 slave: samples MOSI on SCLK rise, drives MISO after
  // SCLK fall, commits a full write frame when CS deasserts.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs_w[i] === 1'b1) begin
        if (s_prev_cs[i] === 1'b0) begin
          last_cmd[i]   = s_cmd[i];
          last_dat[i]   = s_dat[i];
          last_rises[i] = s_rises[i];
          if (s_rises[i] == 16 && s_cmd[i][0] == 1'b0)
            slv_mem[i][s_cmd[i][7:1]] = s_dat[i];
        end
        s_rises[i] = 0;
        s_cmd[i]   = 8'h00;
        s_dat[i]   = 8'h00;
        miso_r[i]  = 1'b0;
      end else if (cs_w[i] === 1'b0) begin
        if (sclk_w[i] === 1'b1 && s_prev_sclk[i] === 1'b0) begin
          if (s_rises[i] < 8) s_cmd[i] = {s_cmd[i][6:0], mosi_w[i]};
          else                s_dat[i] = {s_dat[i][6:0], mosi_w[i]};
          s_rises[i]++;
        end else if (sclk_w[i] === 1'b0 && s_prev_sclk[i] === 1'b1 &&
                     s_rises[i] >= 8 && s_rises[i] < 16 && s_cmd[i][0]) begin
          logic [7:0] rb;
          rb = slv_mem[i][s_cmd[i][7:1]];
          miso_r[i] = rb[15 - s_rises[i]];
        end
      end
      s_prev_sclk[i] = sclk_w[i];
      s_prev_cs[i]   = cs_w[i];
    end
  end

  // Scoreboard monitor: one expected transaction per done pulse; also checks
  // the deselect time between consecutive frames.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int         half;
      exp_t       e;
      logic [7:0] exp_rd;
      half = (i == 0) ? HALF0 : HALF1;
      if (done_w[i] === 1'b1) begin
        done_cnt[i]++;
        if (sb.size() == 0) begin
          checkOutput("done_queue", sb.size(), 32'd1);
        end else begin
          e = sb.pop_front();
          checkOutput("sb_inst", e.inst, i);
          exp_rd = e.rw ? ref_mem[i][e.addr] : last_rdata[i];
          if (!e.rw) ref_mem[i][e.addr] = e.wdata;
          last_rdata[i] = exp_rd;
          checkOutput("rdata", {24'd0, rdata_w[i]}, {24'd0, exp_rd});
          checkOutput("latency", cyc - e.accept, 35 * half + 1);
          checkOutput("cmd_byte", {24'd0, last_cmd[i]}, {24'd0, e.addr, e.rw});
          checkOutput("mosi_data", {24'd0, last_dat[i]},
                      {24'd0, (e.rw ? 8'h00 : e.wdata)});
          checkOutput("sclk_rises", last_rises[i], 16);
        end
      end
      if (cs_w[i] === 1'b0 && m_prev_cs[i] === 1'b1) begin
        if (cs_seen[i]) checkOutput("cs_gap_ok", {31'd0, (cs_run[i] >= half)}, 32'd1);
        cs_seen[i] = 1'b1;
      end
      if (cs_w[i] === 1'b1) cs_run[i]++;
      else                  cs_run[i] = 0;
      m_prev_cs[i] = cs_w[i];
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d;
    logic [6:0] a1;
    logic [7:0] v;
    int n;

    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_r[i] = 1'b0; addr_r[i] = '0; rw_r[i] = 1'b0; wdata_r[i] = '0;
      miso_r[i] = 1'b0; done_cnt[i] = 0; last_rdata[i] = 8'h00;
      s_prev_sclk[i] = 1'b0; s_prev_cs[i] = 1'b1; s_rises[i] = 0;
      s_cmd[i] = '0; s_dat[i] = '0; last_cmd[i] = '0; last_dat[i] = '0;
      last_rises[i] = 0; cs_run[i] = 0; cs_seen[i] = 1'b0; m_prev_cs[i] = 1'b1;
      for (int k = 0; k < 128; k++) begin
        v = 8'($urandom);
        ref_mem[i][k] = v;
        slv_mem[i][k] = v;
      end
    end

    // Power-on reset state
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checkOutput("rst_cs",    {31'd0, cs_w[i]},   32'd1);
      checkOutput("rst_sclk",  {31'd0, sclk_w[i]}, 32'd0);
      checkOutput("rst_mosi",  {31'd0, mosi_w[i]}, 32'd0);
      checkOutput("rst_busy",  {31'd0, busy_w[i]}, 32'd0);
      checkOutput("rst_done",  {31'd0, done_w[i]}, 32'd0);
      checkOutput("rst_rdata", {24'd0, rdata_w[i]}, 32'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);

    // Directed write, then read of the same address with slave data 3C
    applyStimulus(0, 7'h15, 1'b0, 8'hA5, 1'b0);
    waitIdle(0);
    slv_mem[0][7'h15] = 8'h3C;
    ref_mem[0][7'h15] = 8'h3C;
    applyStimulus(0, 7'h15, 1'b1, 8'hFF, 1'b0);
    waitIdle(0);
    checkOutput("read_3c", {24'd0, rdata_w[0]}, 32'h3C);

    // Start pulsed while busy is ignored
    d = done_cnt[0];
    applyStimulus(0, 7'h22, 1'b0, 8'h81, 1'b0);
    repeat (18) @(negedge clk);
    addr_r[0] = 7'h33; rw_r[0] = 1'b1; start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    waitIdle(0);
    repeat (150) @(negedge clk);
    checkOutput("busy_one_done", done_cnt[0] - d, 32'd1);

    // Back-to-back with start held; inputs scrambled mid-frame
    a1 = 7'h4E;
    applyStimulus(0, a1, 1'b0, 8'hC3, 1'b1);
    repeat (30) @(negedge clk);
    addr_r[0] = 7'h01; rw_r[0] = 1'b1; wdata_r[0] = 8'h77;
    n = 0;
    while (done_w[0] !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput("b2b_done_seen", {31'd0, done_w[0]}, 32'd1);
    addr_r[0] = a1; rw_r[0] = 1'b1; wdata_r[0] = 8'h00;
    sb.push_back('{0, a1, 1'b1, 8'h00, cyc + 1});
    @(negedge clk);
    start_r[0] = 1'b0;
    checkOutput("b2b_busy", {31'd0, busy_w[0]}, 32'd1);
    waitIdle(0);
    checkOutput("b2b_readback", {24'd0, rdata_w[0]}, 32'hC3);

    // Reset in the middle of a frame
    applyStimulus(0, 7'h11, 1'b0, 8'h5E, 1'b0);
    repeat (40) @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    last_rdata[0] = 8'h00;
    d = done_cnt[0];
    @(negedge clk);
    checkOutput("mid_rst_cs",    {31'd0, cs_w[0]},   32'd1);
    checkOutput("mid_rst_sclk",  {31'd0, sclk_w[0]}, 32'd0);
    checkOutput("mid_rst_mosi",  {31'd0, mosi_w[0]}, 32'd0);
    checkOutput("mid_rst_busy",  {31'd0, busy_w[0]}, 32'd0);
    checkOutput("mid_rst_rdata", {24'd0, rdata_w[0]}, 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (200) @(negedge clk);
    checkOutput("mid_rst_no_done", done_cnt[0] - d, 32'd0);

    // Randomized traffic over a small address window
    for (int k = 0; k < 24; k++) begin
      applyStimulus(0, 7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    8'($urandom), ($urandom_range(0, 3) == 0));
    end
    start_r[0] = 1'b0;
    waitIdle(0);

    // Slow divider: write 5A to 7F, read it back through the slave
    applyStimulus(1, 7'h7F, 1'b0, 8'h5A, 1'b0);
    waitIdle(1);
    applyStimulus(1, 7'h7F, 1'b1, 8'h00, 1'b0);
    waitIdle(1);
    checkOutput("div16_rdata", {24'd0, rdata_w[1]}, 32'h5A);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_spi_master
